// File: rtl/idiv_iter_if.sv
// Issue-port bundle between the ALU scheduler and the iterative divider.
// Operands carry a pointer-tag bit at the top that the divider ignores.
interface idiv_iter_if #(
    parameter int WIDTH = 64
);
    logic             clkEn;
    logic             en;
    logic [2:0]       op;
    logic [WIDTH:0]   R;
    logic [WIDTH:0]   C;
    logic             busy;
    logic             done;
    logic [WIDTH:0]   Res;
    logic [5:0]       flg;

    modport master (
        output clkEn, en, op, R, C,
        input  busy, done, Res, flg
    );

    modport slave (
        input  clkEn, en, op, R, C,
        output busy, done, Res, flg
    );
endinterface

// File: rtl/idiv_iter.sv
// Radix-2 restoring integer divider, one quotient bit per enabled cycle.
// Divides magnitudes and applies signs at the end; 32-bit mode uses the low half.
//
// state | meaning
// IDLE  | waiting for en; clears done/busy after the done cycle
// LOAD  | screen divide-by-zero / signed overflow, align 32-bit operands
// ITER  | one restoring step per cycle, cnt counts down to 0
// FIX   | apply signs, select quotient/remainder, compute flags, pulse done
module idiv_iter #(
    parameter int WIDTH = 64
) (
    input  logic       clk,
    input  logic       rst,
    idiv_iter_if.slave bus
);
    localparam int H  = WIDTH / 2;
    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_H = {{H{1'b0}}, 1'b1, {(H-1){1'b0}}};
    localparam logic [WIDTH-1:0] MIN_F = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, ITER, FIX} state_t;

    state_t           state;
    logic [2:0]       op_q;
    logic             neg_a, neg_d, dz, ovf;
    logic [WIDTH-1:0] q;
    logic [WIDTH:0]   d_abs;
    logic [WIDTH-1:0] rem;
    logic [CW-1:0]    cnt;
    logic             busy_q, done_q;
    logic [WIDTH:0]   res_q;
    logic [5:0]       flg_q;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.Res  = res_q;
    assign bus.flg  = flg_q;

    logic [WIDTH-1:0] r_ext, c_ext, r_abs, c_abs;
    logic             r_neg, c_neg;

    always_comb begin
        if (bus.op[1]) begin
            r_ext = bus.op[0] ? {{H{bus.R[H-1]}}, bus.R[H-1:0]} : {{H{1'b0}}, bus.R[H-1:0]};
            c_ext = bus.op[0] ? {{H{bus.C[H-1]}}, bus.C[H-1:0]} : {{H{1'b0}}, bus.C[H-1:0]};
        end else begin
            r_ext = bus.R[WIDTH-1:0];
            c_ext = bus.C[WIDTH-1:0];
        end
        r_neg = bus.op[0] & r_ext[WIDTH-1];
        c_neg = bus.op[0] & c_ext[WIDTH-1];
        // Negating MIN yields MIN, which read unsigned is exactly its magnitude.
        r_abs = r_neg ? -r_ext : r_ext;
        c_abs = c_neg ? -c_ext : c_ext;
    end

    logic ov_chk;
    assign ov_chk = op_q[0] && neg_a && neg_d && (d_abs == {{WIDTH{1'b0}}, 1'b1}) &&
                    (q == (op_q[1] ? MIN_H : MIN_F));

    logic [WIDTH:0]   rem_sh;
    logic             ge;
    logic [WIDTH-1:0] rem_nx, q_nx;

    always_comb begin
        rem_sh = {rem, q[WIDTH-1]};
        ge     = (rem_sh >= d_abs);
        rem_nx = ge ? WIDTH'(rem_sh - d_abs) : rem_sh[WIDTH-1:0];
        q_nx   = {q[WIDTH-2:0], ge};
    end

    logic [WIDTH-1:0] quo, rmd, sel, res_nx;
    logic             sf, zf, pf;

    always_comb begin
        // On divide-by-zero q still holds |dividend| since ITER was skipped.
        if (dz) begin
            quo = '1;
            rmd = neg_a ? -q : q;
        end else if (ovf) begin
            quo = op_q[1] ? MIN_H : MIN_F;
            rmd = '0;
        end else begin
            quo = (neg_a ^ neg_d) ? -q : q;
            rmd = neg_a ? -rem : rem;
        end
        sel = op_q[2] ? rmd : quo;
        if (op_q[1])
            res_nx = op_q[0] ? {{H{sel[H-1]}}, sel[H-1:0]} : {{H{1'b0}}, sel[H-1:0]};
        else
            res_nx = sel;
        sf = op_q[1] ? res_nx[H-1] : res_nx[WIDTH-1];
        zf = (res_nx == '0);
        pf = ~^res_nx[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            op_q   <= '0;
            neg_a  <= 1'b0;
            neg_d  <= 1'b0;
            dz     <= 1'b0;
            ovf    <= 1'b0;
            q      <= '0;
            d_abs  <= '0;
            rem    <= '0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            res_q  <= '0;
            flg_q  <= '0;
        end else if (bus.clkEn) begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    if (bus.en && !done_q) begin
                        op_q   <= bus.op;
                        neg_a  <= r_neg;
                        neg_d  <= c_neg;
                        q      <= r_abs;
                        d_abs  <= {1'b0, c_abs};
                        rem    <= '0;
                        busy_q <= 1'b1;
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    dz  <= (d_abs == '0);
                    ovf <= ov_chk;
                    if (d_abs == '0 || ov_chk) begin
                        state <= FIX;
                    end else begin
                        state <= ITER;
                        cnt   <= op_q[1] ? CW'(H - 1) : CW'(WIDTH - 1);
                        if (op_q[1])
                            q <= q << H;
                    end
                end
                ITER: begin
                    rem <= rem_nx;
                    q   <= q_nx;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0)
                        state <= FIX;
                end
                FIX: begin
                    res_q  <= {1'b0, res_nx};
                    flg_q  <= {dz, ovf, 1'b0, sf, zf, pf};
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
